// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time counter.
// Holds the BCD time bundle, the digit maxima and the all-zero time value.
package rtc_pkg;

    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
        logic [3:0] c10;
        logic [3:0] c1;
    } bcd_time_t;

    localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

    localparam bcd_time_t TIME_ZERO = '0;

endpackage

// File: rtl/rtc_time_counter_if.sv
// Control/status bundle of the RTC time counter.
// master drives the controls and reads the times and flags; slave is the counter side.
interface rtc_time_counter_if;
    import rtc_pkg::*;

    logic      countinit;
    logic      countenb;
    logic      latchcount;
    bcd_time_t cur_time;
    bcd_time_t display;
    logic      tick;
    logic      overflow;

    modport master (
        output countinit, countenb, latchcount,
        input  cur_time, display, tick, overflow
    );

    modport slave (
        input  countinit, countenb, latchcount,
        output cur_time, display, tick, overflow
    );

endinterface

// File: rtl/rtc_bcd_digit.sv
// One BCD digit counting 0..MAX with a carry out.
// Ports: i_clk, i_rst_n, i_clr (sync clear), i_inc (advance), o_digit, o_carry.
module rtc_bcd_digit
    import rtc_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_9
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [3:0] r_digit;
    logic       w_at_max;

    // >= rather than == so an out-of-range value still folds back to 0
    assign w_at_max = (r_digit >= MAX);
    assign o_carry  = i_inc && w_at_max;
    assign o_digit  = r_digit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digit <= 4'd0;
        end else if (i_clr) begin
            r_digit <= 4'd0;
        end else if (i_inc) begin
            r_digit <= w_at_max ? 4'd0 : r_digit + 4'd1;
        end
    end

endmodule

// File: rtl/rtc_time_counter.sv
// Stopwatch-style MM:SS:CC BCD counter with prescaler, tick, overflow and display latch.
// Ports: i_sclk, i_reset_n, i_countinit, i_countenb, i_latchcount,
//        o_time, o_display, o_tick, o_overflow.
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int CLKS_PER_TICK = 100000
) (
    input  logic        i_sclk,
    input  logic        i_reset_n,
    input  logic        i_countinit,
    input  logic        i_countenb,
    input  logic        i_latchcount,
    output logic [23:0] o_time,
    output logic [23:0] o_display,
    output logic        o_tick,
    output logic        o_overflow
);

    localparam int PW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLKS_PER_TICK - 1);

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_ovf;
    bcd_time_t     r_disp;

    logic          w_adv;
    bcd_time_t     w_time;
    logic          w_cy_c1;
    logic          w_cy_c10;
    logic          w_cy_s1;
    logic          w_cy_s10;
    logic          w_cy_m1;
    logic          w_cy_m10;

    // enable is sampled at the edge, so a drop on the wrap edge still advances
    assign w_adv = i_countenb && (r_presc >= LAST);

    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc <= '0;
        end else if (i_countinit) begin
            r_presc <= '0;
        end else if (i_countenb) begin
            r_presc <= w_adv ? '0 : r_presc + 1'b1;
        end
    end

    rtc_bcd_digit #(.MAX(DIGIT_MAX_9)) u_c1 (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(i_countinit),
        .i_inc(w_adv), .o_digit(w_time.c1), .o_carry(w_cy_c1)
    );

    rtc_bcd_digit #(.MAX(DIGIT_MAX_9)) u_c10 (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(i_countinit),
        .i_inc(w_cy_c1), .o_digit(w_time.c10), .o_carry(w_cy_c10)
    );

    rtc_bcd_digit #(.MAX(DIGIT_MAX_9)) u_s1 (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(i_countinit),
        .i_inc(w_cy_c10), .o_digit(w_time.s1), .o_carry(w_cy_s1)
    );

    rtc_bcd_digit #(.MAX(DIGIT_MAX_5)) u_s10 (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(i_countinit),
        .i_inc(w_cy_s1), .o_digit(w_time.s10), .o_carry(w_cy_s10)
    );

    rtc_bcd_digit #(.MAX(DIGIT_MAX_9)) u_m1 (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(i_countinit),
        .i_inc(w_cy_s10), .o_digit(w_time.m1), .o_carry(w_cy_m1)
    );

    rtc_bcd_digit #(.MAX(DIGIT_MAX_5)) u_m10 (
        .i_clk(i_sclk), .i_rst_n(i_reset_n), .i_clr(i_countinit),
        .i_inc(w_cy_m1), .o_digit(w_time.m10), .o_carry(w_cy_m10)
    );

    // carry out of the top digit means the wrap 59:59:99 -> 00:00:00
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
            r_disp <= TIME_ZERO;
        end else if (i_countinit) begin
            r_tick <= 1'b0;
            r_ovf  <= 1'b0;
            r_disp <= TIME_ZERO;
        end else begin
            r_tick <= w_adv;
            r_ovf  <= r_ovf | w_cy_m10;
            if (i_latchcount) begin
                r_disp <= w_time;
            end
        end
    end

    assign o_time     = w_time;
    assign o_display  = r_disp;
    assign o_tick     = r_tick;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter with CLKS_PER_TICK=4.
// Expected times are BCD hex literals {m10,m1,s10,s1,c10,c1}.
module tb_rtc_time_counter;
    import rtc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rtc_time_counter_if bus ();

    rtc_time_counter #(.CLKS_PER_TICK(4)) dut (
        .i_sclk      (clk),
        .i_reset_n   (rst_n),
        .i_countinit (bus.countinit),
        .i_countenb  (bus.countenb),
        .i_latchcount(bus.latchcount),
        .o_time      (bus.cur_time),
        .o_display   (bus.display),
        .o_tick      (bus.tick),
        .o_overflow  (bus.overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [23:0] got,
                         input logic [23:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic init_pulse();
        bus.countinit = 1'b1;
        step(1);
        bus.countinit = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        bus.countinit  = 1'b0;
        bus.countenb   = 1'b0;
        bus.latchcount = 1'b0;
        step(2);
        check("rst_time", bus.cur_time, 24'h000000);
        check("rst_disp", bus.display, 24'h000000);
        check("rst_tick", {23'd0, bus.tick}, 24'd0);
        check("rst_ovf", {23'd0, bus.overflow}, 24'd0);
        rst_n = 1'b1;
        step(3);
        check("idle_time", bus.cur_time, 24'h000000);

        // 40 enabled cycles: ticks after edges 4,8,..,40
        init_pulse();
        bus.countenb = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            check($sformatf("tick_c%0d", i), {23'd0, bus.tick},
                  {23'd0, (i % 4) == 0});
        end
        bus.countenb = 1'b0;
        check("run40_time", bus.cur_time, 24'h000010);
        check("run40_ovf", {23'd0, bus.overflow}, 24'd0);

        // split enable: 2 on, 10 off, 2 on
        init_pulse();
        bus.countenb = 1'b1;
        step(2);
        bus.countenb = 1'b0;
        step(10);
        check("hold_time", bus.cur_time, 24'h000000);
        bus.countenb = 1'b1;
        step(1);
        check("en3_time", bus.cur_time, 24'h000000);
        step(1);
        bus.countenb = 1'b0;
        check("en4_time", bus.cur_time, 24'h000001);
        check("en4_tick", {23'd0, bus.tick}, 24'd1);
        step(1);
        check("en4_tick_off", {23'd0, bus.tick}, 24'd0);
        check("en4_hold", bus.cur_time, 24'h000001);

        // minute rollover then the full wrap
        init_pulse();
        bus.countenb = 1'b1;
        step(5999 * 4);
        check("pre_5999", bus.cur_time, 24'h005999);
        step(4);
        check("min_roll", bus.cur_time, 24'h010000);
        check("min_ovf", {23'd0, bus.overflow}, 24'd0);
        step(5999 * 4);
        check("pre_15999", bus.cur_time, 24'h015999);
        bus.countenb = 1'b0;
        force dut.u_m10.r_digit = 4'd5;
        force dut.u_m1.r_digit  = 4'd9;
        #1;
        release dut.u_m10.r_digit;
        release dut.u_m1.r_digit;
        step(1);
        bus.countenb = 1'b1;
        step(3);
        check("wrap_pre", bus.cur_time, 24'h595999);
        check("wrap_pre_ovf", {23'd0, bus.overflow}, 24'd0);
        step(1);
        check("wrap_time", bus.cur_time, 24'h000000);
        check("wrap_ovf", {23'd0, bus.overflow}, 24'd1);
        step(8);
        bus.countenb = 1'b0;
        check("ovf_sticky", {23'd0, bus.overflow}, 24'd1);
        check("post_wrap", bus.cur_time, 24'h000002);
        init_pulse();
        check("ovf_clr", {23'd0, bus.overflow}, 24'd0);
        check("ovf_clr_t", bus.cur_time, 24'h000000);

        // display latch
        bus.latchcount = 1'b1;
        bus.countenb   = 1'b1;
        step(28);
        check("lat_lag", bus.display, 24'h000006);
        step(1);
        bus.latchcount = 1'b0;
        check("lat_7", bus.display, 24'h000007);
        step(51);
        check("frz_time", bus.cur_time, 24'h000020);
        check("frz_disp", bus.display, 24'h000007);
        bus.countenb   = 1'b0;
        bus.latchcount = 1'b1;
        step(1);
        check("relat_disp", bus.display, 24'h000020);

        // async reset between edges
        init_pulse();
        check("init_disp", bus.display, 24'h000000);
        bus.countenb = 1'b1;
        step(20);
        check("pre_rst", bus.cur_time, 24'h000005);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_time", bus.cur_time, 24'h000000);
        check("arst_disp", bus.display, 24'h000000);
        check("arst_tick", {23'd0, bus.tick}, 24'd0);
        check("arst_ovf", {23'd0, bus.overflow}, 24'd0);
        #1;
        rst_n = 1'b1;
        step(3);
        bus.countinit = 1'b1;
        step(1);
        bus.countinit = 1'b0;
        check("init_prio", bus.cur_time, 24'h000000);
        check("init_tick", {23'd0, bus.tick}, 24'd0);
        step(3);
        check("init_pre", bus.cur_time, 24'h000000);
        step(1);
        bus.countenb = 1'b0;
        check("init_adv", bus.cur_time, 24'h000001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_time_counter.md
RTC_TIME_COUNTER -- requirements
Module: rtc_time_counter

Interface
REQ-001 SHALL have parameter CLKS_PER_TICK, default 100000, i_sclk cycles per 0.01 s tick (min 2).
REQ-002 SHALL have port i_sclk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_countinit  input  1  synchronous clear of all time state.
REQ-005 SHALL have port i_countenb  input  1  count enable, level-sensitive.
REQ-006 SHALL have port i_latchcount  input  1  1 = display tracks live time, 0 = display frozen.
REQ-007 SHALL have port o_time  output  24  live time, BCD MM:SS:CC as {m10,m1,s10,s1,c10,c1}, 4 bits each.
REQ-008 SHALL have port o_display  output  24  latched time, same format.
REQ-009 SHALL have port o_tick  output  1  one-cycle pulse on each hundredth increment.
REQ-010 SHALL have port o_overflow  output  1  sticky flag, set on wrap 59:59:99 -> 00:00:00.

Function
REQ-011 Prescaler SHALL count 0..CLKS_PER_TICK-1 only while i_countenb=1, and SHALL hold its value while i_countenb=0.
REQ-012 On an edge with prescaler=CLKS_PER_TICK-1 and i_countenb=1, prescaler SHALL go to 0 and o_time SHALL advance by 0.01 s on that same edge.
REQ-013 o_tick SHALL be registered and high for exactly the cycle after each advance edge.
REQ-014 Digit ranges SHALL be c1 0-9, c10 0-9, s1 0-9, s10 0-5, m1 0-9, m10 0-5; each digit wraps to 0 and carries into the next.
REQ-015 Advance from 59:59:99 SHALL give 00:00:00 and set o_overflow; o_overflow SHALL stay set until i_countinit or reset.
REQ-016 i_countinit=1 SHALL clear prescaler, o_time, o_display, o_tick and o_overflow on that edge, taking priority over i_countenb and i_latchcount.
REQ-017 While i_latchcount=1, o_display SHALL load o_time each edge, so it lags o_time by one cycle.
REQ-018 While i_latchcount=0, o_display SHALL hold; the value frozen is the o_time present at the 1->0 edge.
REQ-019 An enable drop in mid-period followed by re-enable SHALL resume from the held prescaler value, with no lost or extra cycles.
REQ-020 Simultaneous i_countenb 1->0 on an advance edge: the advance SHALL still occur, because the enable is sampled at that edge.
REQ-021 Digit values SHALL never leave their legal BCD range under any input sequence.

Reset
REQ-022 i_reset_n=0 SHALL immediately and asynchronously force prescaler=0, o_time=0, o_display=0, o_tick=0 and o_overflow=0, including in mid-count.
REQ-023 After i_reset_n deasserts, the block SHALL stay idle until i_countenb=1; the first advance SHALL come CLKS_PER_TICK enabled cycles later.

Structure
REQ-024 Shared package rtc_pkg SHALL hold the typedef bcd_time_t (packed struct of six 4-bit digits), the constants for the digit maxima (9/5) and the all-zero time constant.
REQ-025 A sub-module rtc_bcd_digit (parameter MAX; inputs inc and clr; outputs digit and carry) SHALL be instantiated six times and chained by carry.
REQ-026 Prescaler, o_tick, o_overflow and o_display SHALL live in the top module; there SHALL be no combinational path from any input to any output.

Verification (CLKS_PER_TICK=4)
REQ-027 Reset, countinit pulse, enable held 40 cycles -> o_time=00:00:10, 10 o_tick pulses spaced 4 cycles apart, o_overflow=0.
REQ-028 Enable for 2 cycles, disable for 10, enable for 2 -> exactly one advance, landing on the 4th enabled cycle; o_time=00:00:01.
REQ-029 Preload to 00:59:99 by running, then one tick -> 01:00:00; from 59:59:99 one tick -> 00:00:00 with o_overflow=1 held until countinit.
REQ-030 Latch high while running to 00:00:07, drop latch, run to 00:00:20 -> o_display stays 00:00:07; raise latch -> o_display=00:00:20 one cycle later.
REQ-031 Assert i_reset_n=0 between edges at 00:00:05 -> all outputs 0 before the next edge; countinit and enable both 1 on the same edge -> everything cleared and no advance.
